fl_recovery_ctrl: RTL and testbench

//  Sequencer that recovers rename state after a branch mispredict. Walks the squashed ROB entries

---
 rtl/fl_recovery_ctrl.sv | 149 ++++++++++++++
 tb/tb_fl_recovery_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fl_recovery_ctrl.sv
// Branch-mispredict recovery sequencer: walks squashed ROB entries youngest->oldest restoring
// Told into the map table, rolls the freelist tail back, then commands the ROB squash.
module fl_recovery_ctrl #(
    parameter int unsigned C_ROB_ENTRY_NUM = 32,
    parameter int unsigned C_ROB_IDX       = 5,
    parameter int unsigned C_ARCH_REG_NUM  = 32,
    parameter int unsigned C_ARCH_IDX      = 5,
    parameter int unsigned C_PHY_IDX       = 6,
    parameter int unsigned C_WALK_NUM      = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              br_mis_valid_i,
    input  logic [C_ROB_IDX-1:0]              br_mis_rob_idx_i,
    input  logic [C_ROB_IDX-1:0]              rob_tail_i,
    output logic [C_WALK_NUM*C_ROB_IDX-1:0]   rob_rd_idx_o,
    input  logic [C_WALK_NUM*C_ARCH_IDX-1:0]  rob_rd_arch_i,
    input  logic [C_WALK_NUM*C_PHY_IDX-1:0]   rob_rd_tag_i,
    input  logic [C_WALK_NUM*C_PHY_IDX-1:0]   rob_rd_told_i,
    output logic [C_WALK_NUM-1:0]             mt_wr_en_o,
    output logic [C_WALK_NUM*C_ARCH_IDX-1:0]  mt_wr_arch_o,
    output logic [C_WALK_NUM*C_PHY_IDX-1:0]   mt_wr_tag_o,
    output logic                              fl_rollback_o,
    output logic [C_PHY_IDX-1:0]              vfl_tag_o,
    output logic                              rob_squash_o,
    output logic                              dp_stall_o,
    output logic                              busy_o
);

    localparam int unsigned ROB_MASK  = C_ROB_ENTRY_NUM - 1;
    localparam int unsigned ARCH_MASK = C_ARCH_REG_NUM - 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WALK     = 2'd1,
        S_ROLLBACK = 2'd2,
        S_SQUASH   = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [C_ROB_IDX-1:0]   ptr_q, ptr_d;
    logic [C_ROB_IDX-1:0]   cnt_q, cnt_d;
    logic [C_PHY_IDX-1:0]   vfl_q, vfl_d;
    logic                   seen_q, seen_d;

    logic [C_ROB_IDX-1:0]   idx0, idx1, step;
    logic [C_ARCH_IDX-1:0]  arch0, arch1;
    logic [C_PHY_IDX-1:0]   tag0, tag1;
    logic                   nz0, nz1, wr0, wr1;

    // Slot decode: slot0 is the younger entry at ptr, slot1 the older one below it.
    always_comb begin
        idx0  = ptr_q & C_ROB_IDX'(ROB_MASK);
        idx1  = (ptr_q - C_ROB_IDX'(1)) & C_ROB_IDX'(ROB_MASK);
        arch0 = rob_rd_arch_i[C_ARCH_IDX-1:0] & C_ARCH_IDX'(ARCH_MASK);
        arch1 = rob_rd_arch_i[2*C_ARCH_IDX-1:C_ARCH_IDX] & C_ARCH_IDX'(ARCH_MASK);
        tag0  = rob_rd_tag_i[C_PHY_IDX-1:0];
        tag1  = rob_rd_tag_i[2*C_PHY_IDX-1:C_PHY_IDX];
        nz0   = (state_q == S_WALK) && (cnt_q > C_ROB_IDX'(0)) && (tag0 != '0);
        nz1   = (state_q == S_WALK) && (cnt_q > C_ROB_IDX'(1)) && (tag1 != '0);
        wr1   = nz1;
        // Same arch in both slots: the older Told is the one that must survive.
        wr0   = nz0 && !(nz1 && (arch0 == arch1));
        step  = (cnt_q >= C_ROB_IDX'(C_WALK_NUM)) ? C_ROB_IDX'(C_WALK_NUM) : cnt_q;
    end

    // State and walk registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            vfl_q   <= '0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            vfl_q   <= vfl_d;
            seen_q  <= seen_d;
        end
    end

    // Next-state and walk bookkeeping.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        vfl_d   = vfl_q;
        seen_d  = seen_q;
        unique case (state_q)
            S_IDLE: begin
                if (br_mis_valid_i) begin
                    ptr_d   = (rob_tail_i - C_ROB_IDX'(1)) & C_ROB_IDX'(ROB_MASK);
                    cnt_d   = (rob_tail_i - br_mis_rob_idx_i - C_ROB_IDX'(1)) & C_ROB_IDX'(ROB_MASK);
                    vfl_d   = '0;
                    seen_d  = 1'b0;
                    state_d = (cnt_d != '0) ? S_WALK : S_SQUASH;
                end
            end
            S_WALK: begin
                ptr_d = (ptr_q - step) & C_ROB_IDX'(ROB_MASK);
                cnt_d = cnt_q - step;
                if (nz1) begin
                    vfl_d  = tag1;
                    seen_d = 1'b1;
                end else if (nz0) begin
                    vfl_d  = tag0;
                    seen_d = 1'b1;
                end
                if (cnt_d == '0) begin
                    state_d = seen_d ? S_ROLLBACK : S_SQUASH;
                end
            end
            S_ROLLBACK: state_d = S_SQUASH;
            S_SQUASH:   state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Output decode of the registered state.
    always_comb begin
        rob_rd_idx_o  = '0;
        mt_wr_en_o    = '0;
        mt_wr_arch_o  = '0;
        mt_wr_tag_o   = '0;
        fl_rollback_o = 1'b0;
        vfl_tag_o     = '0;
        rob_squash_o  = 1'b0;
        busy_o        = (state_q != S_IDLE);
        unique case (state_q)
            S_WALK: begin
                rob_rd_idx_o = {idx1, idx0};
                mt_wr_en_o   = {wr1, wr0};
                mt_wr_arch_o = {arch1, arch0};
                mt_wr_tag_o  = rob_rd_told_i;
            end
            S_ROLLBACK: begin
                fl_rollback_o = 1'b1;
                vfl_tag_o     = vfl_q;
            end
            S_SQUASH: rob_squash_o = 1'b1;
            default: ;
        endcase
    end

    assign dp_stall_o = br_mis_valid_i | (state_q != S_IDLE);

endmodule

// File: tb/tb_fl_recovery_ctrl.sv
// Scoreboard bench for fl_recovery_ctrl: a ROB image answers the read ports, a reference model
// queues expected restore/rollback/squash events and busy lengths, a monitor compares them.
module tb_fl_recovery_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        br_mis_valid_i;
    logic [4:0]  br_mis_rob_idx_i, rob_tail_i;
    logic [9:0]  rob_rd_idx_o;
    logic [9:0]  rob_rd_arch_i;
    logic [11:0] rob_rd_tag_i, rob_rd_told_i;
    logic [1:0]  mt_wr_en_o;
    logic [9:0]  mt_wr_arch_o;
    logic [11:0] mt_wr_tag_o;
    logic        fl_rollback_o, rob_squash_o, dp_stall_o, busy_o;
    logic [5:0]  vfl_tag_o;

    always #5 clk = ~clk;

    fl_recovery_ctrl dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .br_mis_valid_i(br_mis_valid_i), .br_mis_rob_idx_i(br_mis_rob_idx_i),
        .rob_tail_i(rob_tail_i), .rob_rd_idx_o(rob_rd_idx_o),
        .rob_rd_arch_i(rob_rd_arch_i), .rob_rd_tag_i(rob_rd_tag_i),
        .rob_rd_told_i(rob_rd_told_i), .mt_wr_en_o(mt_wr_en_o),
        .mt_wr_arch_o(mt_wr_arch_o), .mt_wr_tag_o(mt_wr_tag_o),
        .fl_rollback_o(fl_rollback_o), .vfl_tag_o(vfl_tag_o),
        .rob_squash_o(rob_squash_o), .dp_stall_o(dp_stall_o), .busy_o(busy_o)
    );

    // ROB image with same-cycle read ports
    logic [4:0] rob_arch [32];
    logic [5:0] rob_tag  [32];
    logic [5:0] rob_told [32];
    assign rob_rd_arch_i = {rob_arch[rob_rd_idx_o[9:5]], rob_arch[rob_rd_idx_o[4:0]]};
    assign rob_rd_tag_i  = {rob_tag[rob_rd_idx_o[9:5]],  rob_tag[rob_rd_idx_o[4:0]]};
    assign rob_rd_told_i = {rob_told[rob_rd_idx_o[9:5]], rob_told[rob_rd_idx_o[4:0]]};

    localparam logic [1:0] K_WR = 2'd0, K_RB = 2'd1, K_SQ = 2'd2;
    typedef struct packed {
        logic [1:0] kind;
        logic [1:0] en;
        logic [4:0] a1, a0;
        logic [5:0] t1, t0;
    } ev_t;

    ev_t exp_q[$];
    int  lat_q[$];
    int  nvec = 0;
    int  nerr = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // mode 0: random, 1: all zero tags, 2: narrow arch range to force pair collisions
    task automatic fill_rob(input int mode);
        for (int i = 0; i < 32; i++) begin
            rob_arch[i] = (mode == 2) ? 5'($urandom_range(0, 2)) : 5'($urandom_range(0, 31));
            rob_told[i] = 6'($urandom_range(1, 63));
            if (mode == 1 || $urandom_range(0, 3) == 0) rob_tag[i] = 6'd0;
            else rob_tag[i] = 6'($urandom_range(1, 63));
        end
    endtask

    // Reference: squashed entries are tail-1 down to br+1, consumed two at a time.
    task automatic expect_txn(input int br, input int tail);
        int  n, done, cyc, pos0, pos1, i0, i1;
        bit  z0, z1, seen;
        logic [5:0] vfl;
        ev_t e;
        n = (tail - br - 1) & 31;
        done = 0; cyc = 0; seen = 0; vfl = '0;
        while (done < n) begin
            pos0 = done; pos1 = done + 1;
            i0 = (tail - 1 - pos0) & 31;
            i1 = (tail - 1 - pos1) & 31;
            z0 = (pos0 < n) && (rob_tag[i0] != 0);
            z1 = (pos1 < n) && (rob_tag[i1] != 0);
            e = '0;
            e.kind = K_WR;
            e.en[1] = z1;
            e.en[0] = z0 && !(z1 && rob_arch[i0] == rob_arch[i1]);
            if (e.en[0]) begin e.a0 = rob_arch[i0]; e.t0 = rob_told[i0]; end
            if (e.en[1]) begin e.a1 = rob_arch[i1]; e.t1 = rob_told[i1]; end
            if (e.en != 0) exp_q.push_back(e);
            if (z1) begin vfl = rob_tag[i1]; seen = 1; end
            else if (z0) begin vfl = rob_tag[i0]; seen = 1; end
            done += 2;
            cyc++;
        end
        if (seen) begin
            e = '0; e.kind = K_RB; e.t0 = vfl;
            exp_q.push_back(e);
        end
        e = '0; e.kind = K_SQ;
        exp_q.push_back(e);
        lat_q.push_back(cyc + int'(seen) + 1);
    endtask

    task automatic pulse(input int br, input int tail);
        @(posedge clk); #1;
        br_mis_valid_i   = 1'b1;
        br_mis_rob_idx_i = 5'(br);
        rob_tail_i       = 5'(tail);
        #1 check("dp_stall_on_pulse", 64'(dp_stall_o), 64'd1);
        @(posedge clk); #1;
        br_mis_valid_i = 1'b0;
    endtask

    task automatic run_txn(input int br, input int tail);
        expect_txn(br, tail);
        pulse(br, tail);
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 200 && (exp_q.size() != 0 || lat_q.size() != 0); i++) @(posedge clk);
        if (exp_q.size() != 0 || lat_q.size() != 0) begin
            check("txn_timeout_pending", 64'(exp_q.size() + lat_q.size()), 64'd0);
            exp_q.delete();
            lat_q.delete();
        end
        #1;
    endtask

    function automatic logic [63:0] all_outs();
        return {19'd0, mt_wr_en_o, fl_rollback_o, rob_squash_o, busy_o, dp_stall_o,
                vfl_tag_o, rob_rd_idx_o, mt_wr_arch_o, mt_wr_tag_o};
    endfunction

    // Monitor: pops an expected event whenever the DUT presents one
    ev_t got_e, exp_e;
    int  bcnt = 0;
    int  exp_lat;
    always @(negedge clk) begin
        if (!rst_ni) begin
            bcnt = 0;
        end else begin
            if (mt_wr_en_o != 0) begin
                got_e = '0; got_e.kind = K_WR; got_e.en = mt_wr_en_o;
                if (mt_wr_en_o[0]) begin got_e.a0 = mt_wr_arch_o[4:0]; got_e.t0 = mt_wr_tag_o[5:0]; end
                if (mt_wr_en_o[1]) begin got_e.a1 = mt_wr_arch_o[9:5]; got_e.t1 = mt_wr_tag_o[11:6]; end
                exp_e = (exp_q.size() != 0) ? exp_q.pop_front() : ev_t'('1);
                check("map_restore", 64'(got_e), 64'(exp_e));
            end
            if (fl_rollback_o) begin
                got_e = '0; got_e.kind = K_RB; got_e.t0 = vfl_tag_o;
                exp_e = (exp_q.size() != 0) ? exp_q.pop_front() : ev_t'('1);
                check("fl_rollback", 64'(got_e), 64'(exp_e));
            end else begin
                check("vfl_idle_zero", 64'(vfl_tag_o), 64'd0);
            end
            if (rob_squash_o) begin
                got_e = '0; got_e.kind = K_SQ;
                exp_e = (exp_q.size() != 0) ? exp_q.pop_front() : ev_t'('1);
                check("rob_squash", 64'(got_e), 64'(exp_e));
            end
            if (busy_o) begin
                bcnt++;
            end else if (bcnt != 0) begin
                exp_lat = (lat_q.size() != 0) ? lat_q.pop_front() : -1;
                check("busy_cycles", 64'(bcnt), 64'(exp_lat));
                bcnt = 0;
            end
        end
    end

    initial begin
        rst_ni = 1'b0;
        br_mis_valid_i = 1'b0;
        br_mis_rob_idx_i = '0;
        rob_tail_i = '0;
        fill_rob(0);
        repeat (3) @(posedge clk);
        #1 check("reset_outputs", all_outs(), 64'd0);
        @(negedge clk) rst_ni = 1'b1;

        // Directed: basic walk, empty walk, wrap
        run_txn(4, 9);   wait_done();
        run_txn(7, 8);   wait_done();
        run_txn(30, 2);  wait_done();

        // Same-arch pair: older Told must win
        fill_rob(0);
        rob_arch[1] = 5'd5; rob_tag[1] = 6'd20; rob_told[1] = 6'd40;
        rob_arch[2] = 5'd5; rob_tag[2] = 6'd21; rob_told[2] = 6'd44;
        run_txn(0, 3);   wait_done();

        // All zero tags: no restore, no rollback
        fill_rob(1);
        run_txn(12, 20); wait_done();

        // Full ROB (tail == branch) gives the maximum walk
        fill_rob(0);
        run_txn(17, 17); wait_done();

        // Async reset mid-walk
        fill_rob(0);
        run_txn(0, 0);
        repeat (3) @(posedge clk);
        #2 rst_ni = 1'b0;
        #1 check("reset_mid_walk", all_outs(), 64'd0);
        exp_q.delete();
        lat_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_ni = 1'b1;
        #1 check("idle_after_reset", 64'(busy_o), 64'd0);

        // Second mispredict while busy is ignored
        fill_rob(0);
        run_txn(10, 20);
        repeat (2) @(posedge clk);
        pulse(3, 25);
        wait_done();

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            fill_rob($urandom_range(0, 9) == 0 ? 1 : int'($urandom_range(0, 2)) & 2);
            run_txn(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
            wait_done();
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        #1 check("queues_drained", 64'(exp_q.size() + lat_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
